// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU commit stage.
//   - ALU opcode constants (same 6-bit encoding the ALU decodes)
//   - flag bit positions inside the 4-bit {zero, neg, carry, overflow} vector
//   - commit class of an opcode and the helper that decodes it
package alu_writeback_pkg;

  localparam int OPC_W  = 6;
  localparam int FLAG_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADD = 6'h01;
  localparam logic [OPC_W-1:0] OP_SUB = 6'h02;
  localparam logic [OPC_W-1:0] OP_AND = 6'h03;
  localparam logic [OPC_W-1:0] OP_OR  = 6'h04;
  localparam logic [OPC_W-1:0] OP_XOR = 6'h05;
  localparam logic [OPC_W-1:0] OP_SHL = 6'h06;
  localparam logic [OPC_W-1:0] OP_SHR = 6'h07;
  localparam logic [OPC_W-1:0] OP_MOV = 6'h08;
  localparam logic [OPC_W-1:0] OP_CMP = 6'h10;
  localparam logic [OPC_W-1:0] OP_TST = 6'h11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // How an executed instruction is committed.
  typedef enum logic [1:0] {
    CLS_WRITE      = 2'd0,
    CLS_FLAGS_ONLY = 2'd1,
    CLS_NOP        = 2'd2
  } entry_class_e;

  // Anything that is not a compare/test/nop writes its destination register.
  function automatic entry_class_e decode_class(input logic [OPC_W-1:0] opcode);
    entry_class_e cls;
    case (opcode)
      OP_NOP:         cls = CLS_NOP;
      OP_CMP, OP_TST: cls = CLS_FLAGS_ONLY;
      default:        cls = CLS_WRITE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Bus bundle between the ALU, the commit stage, the register file write port
// and the operand-stage forwarding lookup.
//   ALU side      : in_valid/in_ready handshake, in_opcode, in_dest, in_result, in_flags
//   RF side       : rf_we, rf_waddr, rf_wdata requested; rf_grant returned
//   status        : architectural flags register
//   forwarding    : lookup_addr query, lookup_hit/lookup_data answer
// The slave modport is the commit stage's view; master is its environment.
interface alu_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_flags;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_grant;

  logic [3:0]        status;

  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;

  modport slave (
    input  in_valid, in_opcode, in_dest, in_result, in_flags,
    input  rf_grant, lookup_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata, status, lookup_hit, lookup_data
  );

  modport master (
    output in_valid, in_opcode, in_dest, in_result, in_flags,
    output rf_grant, lookup_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, status, lookup_hit, lookup_data
  );

endinterface

// File: rtl/alu_writeback_wb_fifo.sv
// wb_fifo: generic in-order buffer of DEPTH entries, WIDTH bits each.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   push, push_data : write one entry (ignored when full)
//   pop             : drop the oldest entry (ignored when empty)
//   full, empty     : occupancy flags
//   ordered_data    : every slot, index 0 = oldest (head) upward to youngest
//   ordered_valid   : which of ordered_data hold live entries
// Presenting the slots in age order lets the consumer do a priority search
// (youngest match wins) without knowing the pointer values.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][WIDTH-1:0] ordered_data,
  output logic [DEPTH-1:0]            ordered_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy. Pointers are PTR_W bits wide and DEPTH is
  // a power of two, so wrap-around is just natural overflow. Push and pop in
  // the same cycle move both pointers and leave count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Rotate the storage so slot k is the k-th oldest entry.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ordered_data[k]  = mem[rd_ptr + PTR_W'(k)];
      ordered_valid[k] = (CNT_W'(k) < count);
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: commit stage behind the 16-bit ALU.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : alu_writeback_if slave port
//                - accepts ALU results (in_valid/in_ready, opcode, dest, result, flags)
//                - writes them to the register file in order (rf_we/rf_waddr/rf_wdata,
//                  retiring on rf_grant)
//                - holds the architectural status flags, updated in commit order
//                - answers forwarding queries for results still buffered
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           reset,
  alu_writeback_if.slave bus
);

  // Entry layout: {is_write, flags, result, dest}
  localparam int DEST_LSB = 0;
  localparam int RES_LSB  = ADDR_W;
  localparam int FLG_LSB  = ADDR_W + DATA_W;
  localparam int WR_BIT   = ADDR_W + DATA_W + FLAG_W;
  localparam int ENTRY_W  = WR_BIT + 1;

  entry_class_e                  in_class;
  logic                          push;
  logic                          pop;
  logic                          full;
  logic                          empty;
  logic [ENTRY_W-1:0]            push_entry;
  logic [DEPTH-1:0][ENTRY_W-1:0] ent;
  logic [DEPTH-1:0]              ent_valid;

  logic                          head_is_write;
  logic [ADDR_W-1:0]             head_dest;
  logic [DATA_W-1:0]             head_result;
  logic [FLAG_W-1:0]             head_flags;
  logic                          rf_we_int;
  logic [FLAG_W-1:0]             status_q;
  logic                          unused_flag_bits;

  // Classify at the input; NOPs are acknowledged but never stored. A full
  // buffer refuses everything, including NOPs, even on a retiring cycle.
  always_comb begin
    in_class   = decode_class(bus.in_opcode);
    push       = bus.in_valid && !full && (in_class != CLS_NOP);
    push_entry = {(in_class == CLS_WRITE), bus.in_flags, bus.in_result, bus.in_dest};
  end

  assign bus.in_ready = !full;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_data     (push_entry),
    .pop           (pop),
    .full          (full),
    .empty         (empty),
    .ordered_data  (ent),
    .ordered_valid (ent_valid)
  );

  // Retire control for the head entry. Register writes wait for the grant;
  // flag-only entries leave one cycle after reaching the head. The write
  // address/data are forced to zero whenever no write is being requested.
  always_comb begin
    head_is_write = ent[0][WR_BIT];
    head_dest     = ent[0][DEST_LSB +: ADDR_W];
    head_result   = ent[0][RES_LSB +: DATA_W];
    head_flags    = ent[0][FLG_LSB +: FLAG_W];
    rf_we_int     = !empty && head_is_write;
    pop           = !empty && (!head_is_write || bus.rf_grant);
  end

  assign bus.rf_we    = rf_we_int;
  assign bus.rf_waddr = rf_we_int ? head_dest   : '0;
  assign bus.rf_wdata = rf_we_int ? head_result : '0;

  // Architectural flags take the retiring entry's flags, so they change in
  // the same order as the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else if (pop) begin
      status_q <= head_flags;
    end
  end

  assign bus.status = status_q;

  // Forwarding search from oldest to youngest so the last match, i.e. the
  // youngest pending write to that register, is the one reported. The head
  // still matches during its retire cycle. Flags of non-head slots take no
  // part in forwarding and are folded into a sink.
  always_comb begin
    bus.lookup_hit   = 1'b0;
    bus.lookup_data  = '0;
    unused_flag_bits = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      unused_flag_bits = unused_flag_bits ^ (^ent[k][FLG_LSB +: FLAG_W]);
      if (ent_valid[k] && ent[k][WR_BIT] &&
          (ent[k][DEST_LSB +: ADDR_W] == bus.lookup_addr)) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = ent[k][RES_LSB +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios followed by a
// randomized run compared against a queue-based model of the commit stage.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alu_writeback #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    bit                wr;
  } model_entry_t;

  model_entry_t mq[$];
  logic [3:0]   m_status;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [ADDR_W-1:0] d,
                       input logic [DATA_W-1:0] r, input logic [3:0] f);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_dest   = d;
    bus.in_result = r;
    bus.in_flags  = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, OP_NOP, '0, '0, '0);
    bus.rf_grant    = 1'b0;
    bus.lookup_addr = '0;
    step();
    step();
    reset = 1'b0;
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 3'd0) begin errors++; $display("[TB] FAIL reset_rf_waddr: got %h expected 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rf_wdata: got %h expected 0", bus.rf_wdata); end
    checks++; if (bus.status !== 4'b0000) begin errors++; $display("[TB] FAIL reset_status: got %b expected 0000", bus.status); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_lookup_hit: got %b expected 0", bus.lookup_hit); end
    checks++; if (bus.lookup_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_lookup_data: got %h expected 0", bus.lookup_data); end
  endtask

  task automatic test_write_single();
    bus.rf_grant = 1'b1;
    drive(1'b1, OP_ADD, 3'd3, 16'h1234, 4'b0000);
    settle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL write_pre_rf_we: got %b expected 0", bus.rf_we); end
    step();
    drive(1'b0, OP_NOP, '0, '0, '0);
    bus.lookup_addr = 3'd3;
    settle();
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL write_rf_we: got %b expected 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 3'd3) begin errors++; $display("[TB] FAIL write_rf_waddr: got %h expected 3", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL write_rf_wdata: got %h expected 1234", bus.rf_wdata); end
    checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 16'h1234) begin errors++; $display("[TB] FAIL write_retire_hit: got %b/%h expected 1/1234", bus.lookup_hit, bus.lookup_data); end
    step();
    settle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL write_post_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.status !== 4'b0000) begin errors++; $display("[TB] FAIL write_status: got %b expected 0000", bus.status); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL write_post_hit: got %b expected 0", bus.lookup_hit); end
  endtask

  task automatic test_flags_only();
    bus.rf_grant = 1'b0;
    drive(1'b1, OP_CMP, 3'd5, 16'h0000, 4'b1000);
    step();
    drive(1'b0, OP_NOP, '0, '0, '0);
    bus.lookup_addr = 3'd5;
    settle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL cmp_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL cmp_no_forward: got %b expected 0", bus.lookup_hit); end
    checks++; if (bus.status !== 4'b0000) begin errors++; $display("[TB] FAIL cmp_status_early: got %b expected 0000", bus.status); end
    step();
    settle();
    checks++; if (bus.status !== 4'b1000) begin errors++; $display("[TB] FAIL cmp_status: got %b expected 1000", bus.status); end
    drive(1'b1, OP_NOP, 3'd5, 16'hFFFF, 4'b0001);
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nop_in_ready: got %b expected 1", bus.in_ready); end
    step();
    drive(1'b0, OP_NOP, '0, '0, '0);
    settle();
    checks++; if (bus.rf_we !== 1'b0 || bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL nop_not_buffered: got we=%b hit=%b expected 0/0", bus.rf_we, bus.lookup_hit); end
    step();
    settle();
    checks++; if (bus.status !== 4'b1000) begin errors++; $display("[TB] FAIL nop_status: got %b expected 1000", bus.status); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nop_empty: got in_ready %b expected 1", bus.in_ready); end
  endtask

  task automatic test_backpressure();
    bus.rf_grant = 1'b0;
    drive(1'b1, OP_ADD, 3'd1, 16'hAAAA, 4'b0001);
    step();
    drive(1'b1, OP_SUB, 3'd1, 16'hBBBB, 4'b0010);
    step();
    drive(1'b1, OP_XOR, 3'd2, 16'hCCCC, 4'b0100);
    bus.lookup_addr = 3'd1;
    settle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 16'hBBBB) begin errors++; $display("[TB] FAIL full_youngest_hit: got %b/%h expected 1/bbbb", bus.lookup_hit, bus.lookup_data); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd1 || bus.rf_wdata !== 16'hAAAA) begin errors++; $display("[TB] FAIL stall_head: got %b/%h/%h expected 1/1/aaaa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    settle();
    checks++; if (bus.rf_wdata !== 16'hAAAA || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold: got %h/%b expected aaaa/0", bus.rf_wdata, bus.in_ready); end
    bus.rf_grant = 1'b1;
    settle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_retiring_in_ready: got %b expected 0", bus.in_ready); end
    step();
    bus.rf_grant = 1'b0;
    settle();
    checks++; if (bus.in_ready !== 1'b1 || bus.rf_wdata !== 16'hBBBB) begin errors++; $display("[TB] FAIL after_retire: got %b/%h expected 1/bbbb", bus.in_ready, bus.rf_wdata); end
    checks++; if (bus.status !== 4'b0001) begin errors++; $display("[TB] FAIL after_retire_status: got %b expected 0001", bus.status); end
    step();
    drive(1'b0, OP_NOP, '0, '0, '0);
    bus.lookup_addr = 3'd2;
    settle();
    checks++; if (bus.in_ready !== 1'b0 || bus.lookup_hit !== 1'b1 || bus.lookup_data !== 16'hCCCC) begin errors++; $display("[TB] FAIL held_push: got %b/%b/%h expected 0/1/cccc", bus.in_ready, bus.lookup_hit, bus.lookup_data); end
    bus.rf_grant = 1'b1;
    step();
    settle();
    checks++; if (bus.rf_wdata !== 16'hCCCC || bus.rf_waddr !== 3'd2 || bus.status !== 4'b0010) begin errors++; $display("[TB] FAIL drain_order: got %h/%h/%b expected cccc/2/0010", bus.rf_wdata, bus.rf_waddr, bus.status); end
    step();
    settle();
    checks++; if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1 || bus.status !== 4'b0100) begin errors++; $display("[TB] FAIL drained: got %b/%b/%b expected 0/1/0100", bus.rf_we, bus.in_ready, bus.status); end
    bus.rf_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] prev;
    prev = '0;
    bus.rf_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, OP_ADD, ADDR_W'(i), 16'h5000 + 16'(i), 4'(i));
      settle();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      if (i > 0) begin
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== prev) begin errors++; $display("[TB] FAIL b2b_write[%0d]: got %b/%h expected 1/%h", i, bus.rf_we, bus.rf_wdata, prev); end
      end
      prev = 16'h5000 + 16'(i);
      step();
    end
    drive(1'b0, OP_NOP, '0, '0, '0);
    settle();
    checks++; if (bus.rf_wdata !== 16'h5009) begin errors++; $display("[TB] FAIL b2b_last: got %h expected 5009", bus.rf_wdata); end
    step();
    settle();
    checks++; if (bus.rf_we !== 1'b0 || bus.status !== 4'b1001) begin errors++; $display("[TB] FAIL b2b_end: got %b/%b expected 0/1001", bus.rf_we, bus.status); end
    bus.rf_grant = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bus.rf_grant = 1'b0;
    drive(1'b1, OP_ADD, 3'd4, 16'h1111, 4'b1111);
    step();
    drive(1'b1, OP_MOV, 3'd6, 16'h2222, 4'b0110);
    step();
    drive(1'b0, OP_NOP, '0, '0, '0);
    settle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_full: got %b expected 0", bus.in_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.lookup_addr = 3'd4;
    settle();
    checks++; if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_flush: got we=%b ready=%b expected 0/1", bus.rf_we, bus.in_ready); end
    checks++; if (bus.status !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_status: got %b expected 0000", bus.status); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("[TB] FAIL midreset_hit: got %b expected 0", bus.lookup_hit); end
    bus.rf_grant = 1'b1;
    step();
    settle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_write: got %b expected 0", bus.rf_we); end
    bus.rf_grant = 1'b0;
  endtask

  // Randomized traffic against a queue model: the queue holds pending commits
  // in order; the head leaves when it is flags-only or the write is granted.
  task automatic test_random();
    logic [5:0]        ops [8];
    logic              e_hit;
    logic [DATA_W-1:0] e_data;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_ready;
    bit                accept;
    bit                retire;
    ops = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_TST, OP_MOV, OP_XOR};
    reset = 1'b1;
    step();
    reset = 1'b0;
    mq.delete();
    m_status = 4'b0000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 7)], ADDR_W'($urandom_range(0, 7)),
            DATA_W'($urandom), 4'($urandom));
      bus.rf_grant    = ($urandom_range(0, 2) != 0);
      bus.lookup_addr = ADDR_W'($urandom_range(0, 7));
      settle();
      e_ready = (mq.size() < DEPTH);
      e_we    = (mq.size() > 0) && mq[0].wr;
      e_addr  = e_we ? mq[0].dest : '0;
      e_wdata = e_we ? mq[0].result : '0;
      e_hit   = 1'b0;
      e_data  = '0;
      foreach (mq[j]) begin
        if (mq[j].wr && mq[j].dest == bus.lookup_addr) begin
          e_hit  = 1'b1;
          e_data = mq[j].result;
        end
      end
      checks++; if (bus.in_ready !== e_ready) begin errors++; $display("[TB] FAIL rand_in_ready@%0d: got %b expected %b", cyc, bus.in_ready, e_ready); end
      checks++; if (bus.rf_we !== e_we || bus.rf_waddr !== e_addr || bus.rf_wdata !== e_wdata) begin errors++; $display("[TB] FAIL rand_rf@%0d: got %b/%h/%h expected %b/%h/%h", cyc, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e_we, e_addr, e_wdata); end
      checks++; if (bus.status !== m_status) begin errors++; $display("[TB] FAIL rand_status@%0d: got %b expected %b", cyc, bus.status, m_status); end
      checks++; if (bus.lookup_hit !== e_hit || bus.lookup_data !== e_data) begin errors++; $display("[TB] FAIL rand_lookup@%0d: got %b/%h expected %b/%h", cyc, bus.lookup_hit, bus.lookup_data, e_hit, e_data); end
      accept = bus.in_valid && (mq.size() < DEPTH) && (bus.in_opcode != OP_NOP);
      retire = (mq.size() > 0) && (!mq[0].wr || bus.rf_grant);
      if (retire) begin
        m_status = mq[0].flags;
        void'(mq.pop_front());
      end
      if (accept) begin
        mq.push_back('{dest: bus.in_dest, result: bus.in_result, flags: bus.in_flags,
                       wr: !(bus.in_opcode == OP_CMP || bus.in_opcode == OP_TST)});
      end
      step();
    end
    drive(1'b0, OP_NOP, '0, '0, '0);
    bus.rf_grant = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, OP_NOP, '0, '0, '0);
    bus.rf_grant    = 1'b0;
    bus.lookup_addr = '0;
    test_reset();
    test_write_single();
    test_flags_only();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
